// File: rtl/cruise_control.sv
// Cruise-control FSM: edge-detected buttons, saturating set-speed, registered accel/brake commands.
// Optional autobrake term enabled by defining CRUISE_AUTOBRAKE_EN.
module cruise_control #(
    parameter int unsigned MIN_SPEED = 30,
    parameter int unsigned MAX_SPEED = 99,
    parameter int unsigned STEP      = 5,
    parameter int unsigned HYST      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cruise_en,
    input  logic       set_btn,
    input  logic       res_btn,
    input  logic       cancel_btn,
    input  logic       accel_pedal,
    input  logic       brake_pedal,
    input  logic [3:0] gear,
    input  logic [7:0] velocity,
    output logic       accel_out,
    output logic       brake_out,
    output logic [7:0] set_speed,
    output logic [1:0] state,
    output logic       active
);

    typedef enum logic [1:0] {
        StOff       = 2'd0,
        StStandby   = 2'd1,
        StEngaged   = 2'd2,
        StSuspended = 2'd3
    } state_e;

    localparam logic [9:0] MinS  = 10'(MIN_SPEED);
    localparam logic [9:0] MaxS  = 10'(MAX_SPEED);
    localparam logic [9:0] StepS = 10'(STEP);
    localparam logic [9:0] HystS = 10'(HYST);

    state_e     state_q, state_d;
    logic [7:0] set_speed_q, set_speed_d;
    logic       set_prev_q, res_prev_q, cancel_prev_q;
    logic       accel_d, brake_d;

    logic       set_ev, res_ev, cancel_ev;
    logic       fwd, in_range, engaged_d, autobrake;
    logic [9:0] vel_w, sp_w, spd_w, sp_up, sp_dn;

    assign set_ev    = set_btn & ~set_prev_q;
    assign res_ev    = res_btn & ~res_prev_q;
    assign cancel_ev = cancel_btn & ~cancel_prev_q;

    assign fwd      = (gear >= 4'd1) && (gear <= 4'd5);
    assign vel_w    = {2'b00, velocity};
    assign sp_w     = {2'b00, set_speed_q};
    assign in_range = (vel_w >= MinS) && (vel_w <= MaxS);

    // Widened arithmetic so adjustments saturate instead of wrapping.
    assign sp_up = (sp_w + StepS > MaxS) ? MaxS : sp_w + StepS;
    assign sp_dn = (sp_w >= MinS + StepS) ? sp_w - StepS : MinS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StOff;
            set_speed_q   <= 8'd0;
            accel_out     <= 1'b0;
            brake_out     <= 1'b0;
            // History starts high so a button held through reset yields no event.
            set_prev_q    <= 1'b1;
            res_prev_q    <= 1'b1;
            cancel_prev_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            set_speed_q   <= set_speed_d;
            accel_out     <= accel_d;
            brake_out     <= brake_d;
            set_prev_q    <= set_btn;
            res_prev_q    <= res_btn;
            cancel_prev_q <= cancel_btn;
        end
    end

    always_comb begin
        state_d     = state_q;
        set_speed_d = set_speed_q;
        if (!cruise_en) begin
            state_d     = StOff;
            set_speed_d = 8'd0;
        end else begin
            case (state_q)
                StOff: state_d = StStandby;
                StStandby: begin
                    if (!brake_pedal && fwd && !cancel_ev && set_ev && in_range) begin
                        state_d     = StEngaged;
                        set_speed_d = velocity;
                    end
                end
                StEngaged: begin
                    if (brake_pedal || !fwd || cancel_ev) begin
                        state_d = StSuspended;
                    end else if (set_ev && !res_ev) begin
                        set_speed_d = sp_dn[7:0];
                    end else if (res_ev && !set_ev) begin
                        set_speed_d = sp_up[7:0];
                    end
                end
                StSuspended: begin
                    if (!brake_pedal && fwd && !cancel_ev) begin
                        if (res_ev && (set_speed_q != 8'd0) && (vel_w >= MinS)) begin
                            state_d = StEngaged;
                        end else if (set_ev && in_range) begin
                            state_d     = StEngaged;
                            set_speed_d = velocity;
                        end
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    assign engaged_d = (state_d == StEngaged);
    assign spd_w     = {2'b00, set_speed_d};

`ifdef CRUISE_AUTOBRAKE_EN
    assign autobrake = engaged_d && !accel_pedal && (vel_w > spd_w + HystS);
`else
    assign autobrake = 1'b0;
`endif

    always_comb begin
        accel_d = 1'b0;
        if (!brake_pedal) begin
            accel_d = accel_pedal || (engaged_d && (vel_w + HystS < spd_w));
        end
        brake_d = brake_pedal || autobrake;
    end

    assign state     = state_q;
    assign set_speed = set_speed_q;
    assign active    = (state_q == StEngaged);

endmodule

// File: tb/tb_cruise_control.sv
// Table-driven bench for cruise_control; expected outputs queued on drive, compared after the edge.
module tb_cruise_control;

    logic       clk = 1'b0;
    logic       rst, cruise_en, set_btn, res_btn, cancel_btn, accel_pedal, brake_pedal;
    logic [3:0] gear;
    logic [7:0] velocity;
    logic       accel_out, brake_out, active;
    logic [7:0] set_speed;
    logic [1:0] state;

`ifdef CRUISE_AUTOBRAKE_EN
    localparam logic AB = 1'b1;
`else
    localparam logic AB = 1'b0;
`endif

    typedef struct {
        logic       rst, en, set, res, cancel, acc_p, brk_p;
        logic [3:0] gear;
        logic [7:0] vel;
        logic [1:0] st;
        logic [7:0] sp;
        logic       acc, brk;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cruise_control dut (
        .clk        (clk),
        .rst        (rst),
        .cruise_en  (cruise_en),
        .set_btn    (set_btn),
        .res_btn    (res_btn),
        .cancel_btn (cancel_btn),
        .accel_pedal(accel_pedal),
        .brake_pedal(brake_pedal),
        .gear       (gear),
        .velocity   (velocity),
        .accel_out  (accel_out),
        .brake_out  (brake_out),
        .set_speed  (set_speed),
        .state      (state),
        .active     (active)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic s, input logic rs,
                                input logic c, input logic ap, input logic bp,
                                input logic [3:0] g, input logic [7:0] v, input logic [1:0] st,
                                input logic [7:0] sp, input logic acc, input logic brk);
        vec_t x;
        x.rst = r; x.en = e; x.set = s; x.res = rs; x.cancel = c; x.acc_p = ap; x.brk_p = bp;
        x.gear = g; x.vel = v; x.st = st; x.sp = sp; x.acc = acc; x.brk = brk;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        rst = v.rst; cruise_en = v.en; set_btn = v.set; res_btn = v.res;
        cancel_btn = v.cancel; accel_pedal = v.acc_p; brake_pedal = v.brk_p;
        gear = v.gear; velocity = v.vel;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("state", idx, {6'd0, state}, {6'd0, e.st});
        chk("set_speed", idx, set_speed, e.sp);
        chk("accel_out", idx, {7'd0, accel_out}, {7'd0, e.acc});
        chk("brake_out", idx, {7'd0, brake_out}, {7'd0, e.brk});
        chk("active", idx, {7'd0, active}, {7'd0, (e.st == 2'd2)});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //             rst en st rs cn ap bp gear vel  st  sp  acc brk
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 50, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 50, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 50, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 50, 2, 50, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 48, 2, 50, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 50, 2, 50, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 52, 2, 50, 0, AB));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 51, 2, 50, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 3, 50, 2, 50, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 50, 3, 50, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 40, 3, 50, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 3, 40, 2, 50, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 50, 2, 50, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 3, 50, 3, 50, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 97, 2, 97, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 3, 99, 2, 99, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 99, 2, 99, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 3, 99, 2, 99, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 32, 2, 99, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 3, 32, 3, 99, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 32, 2, 32, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 32, 2, 32, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 30, 2, 30, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 30, 2, 30, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 3, 30, 2, 30, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 30, 2, 30, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 6, 30, 3, 30, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 30, 3, 30, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 30, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 20, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 20, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 6, 50, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 6, 50, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 50, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 50, 2, 50, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 50, 2, 50, 0, 0));

        rst = 1'b1; cruise_en = 1'b0; set_btn = 1'b0; res_btn = 1'b0; cancel_btn = 1'b0;
        accel_pedal = 1'b0; brake_pedal = 1'b0; gear = 4'd3; velocity = 8'd50;

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset while engaged with SET held: no engage afterwards while it stays held.
        apply(mk(1, 1, 1, 0, 0, 1, 0, 3, 50, 0, 0, 0, 0), 100);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 3, 50, 1, 0, 0, 0), 101);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 3, 50, 1, 0, 0, 0), 102);
        apply(mk(0, 1, 0, 0, 0, 0, 0, 3, 50, 1, 0, 0, 0), 103);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 3, 50, 2, 50, 0, 0), 104);
        // Held RES gives a single increment.
        apply(mk(0, 1, 1, 1, 0, 0, 0, 3, 45, 2, 55, 1, 0), 105);
        apply(mk(0, 1, 1, 1, 0, 0, 0, 3, 45, 2, 55, 1, 0), 106);
        // Dropping the master switch while engaged; brake still passes through in OFF.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 3, 45, 0, 0, 0, 0), 107);
        apply(mk(0, 0, 0, 0, 0, 0, 1, 3, 45, 0, 0, 0, 1), 108);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
